// File: rtl/token_unembed_argmax_pkg.sv
// Shared defaults, FSM encoding and the embedding weight pattern for the unembed/argmax block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package token_unembed_argmax_pkg;

  localparam int VOCAB_SIZE_DEF = 16;
  localparam int N_EMBD_DEF     = 8;
  localparam int DATA_W_DEF     = 8;
  localparam int ACC_W_DEF      = DATA_W_DEF + DATA_W_DEF + 1 + $clog2(N_EMBD_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Tied embedding weight W[t][e] = (t*n_embd + e) mod 2^data_w, as an unsigned value.
  // The same pattern serves the token lookup path and the unembedding path.
  function automatic int embed_weight(input int t, input int e, input int n_embd, input int data_w);
    int mask;
    mask = (1 << data_w) - 1;
    return (t * n_embd + e) & mask;
  endfunction

endpackage

// File: rtl/embed_weight_rom.sv
// Combinational weight table: returns one N_EMBD-element row of the tied embedding matrix.
// Latency: 0 cycles (pure combinational lookup).
// Backpressure: none; the caller owns sequencing of the row index.
module embed_weight_rom
  import token_unembed_argmax_pkg::*;
#(
  parameter int VOCAB_SIZE = VOCAB_SIZE_DEF,
  parameter int N_EMBD     = N_EMBD_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic [$clog2(VOCAB_SIZE)-1:0] row_idx,
  output logic [N_EMBD*DATA_W-1:0]      row_dat
);

  // Build the requested row element by element from the shared weight pattern.
  always_comb begin
    row_dat = '0;
    for (int e = 0; e < N_EMBD; e++) begin
      row_dat[e*DATA_W +: DATA_W] = DATA_W'(embed_weight(int'(row_idx), e, N_EMBD, DATA_W));
    end
  end

endmodule

// File: rtl/token_unembed_argmax.sv
// Projects a hidden vector onto every vocabulary row of the tied embedding and returns the argmax token.
// Latency: out_valid rises VOCAB_SIZE edges after the accepting edge (one row per cycle).
// Backpressure: one transaction in flight; in_ready only in IDLE, result held in DONE until out_ready.
module token_unembed_argmax
  import token_unembed_argmax_pkg::*;
#(
  parameter int VOCAB_SIZE = VOCAB_SIZE_DEF,
  parameter int N_EMBD     = N_EMBD_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [N_EMBD*DATA_W-1:0]                  in_vec,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [$clog2(VOCAB_SIZE)-1:0]             out_token_id,
  output logic [2*DATA_W+$clog2(N_EMBD):0]          out_score
);

  localparam int IDX_W  = $clog2(VOCAB_SIZE);
  localparam int PROD_W = 2 * DATA_W + 1;
  localparam int ACC_W  = DATA_W + DATA_W + 1 + $clog2(N_EMBD);

  state_t                     state;
  state_t                     state_d;
  logic [N_EMBD*DATA_W-1:0]   vec_q;
  logic [IDX_W-1:0]           row_idx;
  logic [N_EMBD*DATA_W-1:0]   w_row;
  logic                       last_row;

  logic signed [DATA_W-1:0]   elem [N_EMBD];
  logic signed [DATA_W:0]     wgt  [N_EMBD];
  logic signed [PROD_W-1:0]   prod [N_EMBD];
  logic signed [ACC_W-1:0]    row_score;

  logic signed [ACC_W-1:0]    best_score;
  logic [IDX_W-1:0]           best_id;
  logic                       take;
  logic signed [ACC_W-1:0]    cand_score;
  logic [IDX_W-1:0]           cand_id;

  embed_weight_rom #(
    .VOCAB_SIZE (VOCAB_SIZE),
    .N_EMBD     (N_EMBD),
    .DATA_W     (DATA_W)
  ) u_rom (
    .row_idx (row_idx),
    .row_dat (w_row)
  );

  assign last_row = (row_idx == IDX_W'(VOCAB_SIZE - 1));

  // Row dot product: all N_EMBD signed x zero-extended-weight products in parallel, summed at full width.
  always_comb begin
    row_score = '0;
    for (int e = 0; e < N_EMBD; e++) begin
      elem[e]   = vec_q[e*DATA_W +: DATA_W];
      wgt[e]    = {1'b0, w_row[e*DATA_W +: DATA_W]};
      prod[e]   = PROD_W'(elem[e]) * PROD_W'(wgt[e]);
      row_score = row_score + ACC_W'(prod[e]);
    end
  end

  // Running argmax: row 0 always loads, later rows only on a strictly greater score (ties keep lowest index).
  always_comb begin
    take       = (row_idx == '0) || (row_score > best_score);
    cand_score = take ? row_score : best_score;
    cand_id    = take ? row_idx   : best_id;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = SCAN;
      end
      SCAN: begin
        if (last_row) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch the vector on accept, step rows during SCAN, publish the winner on the last row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q        <= '0;
      row_idx      <= '0;
      best_score   <= '0;
      best_id      <= '0;
      out_token_id <= '0;
      out_score    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            vec_q   <= in_vec;
            row_idx <= '0;
          end
        end
        SCAN: begin
          best_score <= cand_score;
          best_id    <= cand_id;
          if (last_row) begin
            out_token_id <= cand_id;
            out_score    <= cand_score;
          end else begin
            row_idx <= row_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_token_unembed_argmax.sv
// Directed bench for token_unembed_argmax at default parameters.
// Latency: checks out_valid rising 16 edges after each accept.
// Backpressure: exercises DONE stalls, ignored input outside IDLE and mid-scan reset.
module tb_token_unembed_argmax;
  import token_unembed_argmax_pkg::*;

  logic                        clk;
  logic                        rst_n;
  logic                        in_valid;
  logic                        in_ready;
  logic [63:0]                 in_vec;
  logic                        out_valid;
  logic                        out_ready;
  logic [3:0]                  out_token_id;
  logic signed [ACC_W_DEF-1:0] out_score;

  int vectors;
  int miscompares;
  int last_tok;
  int last_score;

  token_unembed_argmax #(
    .VOCAB_SIZE (16),
    .N_EMBD     (8),
    .DATA_W     (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_vec       (in_vec),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_token_id (out_token_id),
    .out_score    (out_score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] splat(input logic [7:0] b);
    return {8{b}};
  endfunction

  // One full transaction: accept, scan with garbage on the inputs, optional DONE stall, handshake.
  task automatic run_txn(input string tag, input logic [63:0] vec, input int exp_tok,
                         input int exp_score, input int stall);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, "_ready"}, in_ready, 1);
    in_vec   = vec;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_vec = ~vec;
    check({tag, "_busy"}, in_ready, 0);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (cyc == 8) begin
        check({tag, "_hold_tok"}, out_token_id, last_tok);
        check({tag, "_hold_score"}, out_score, last_score);
      end
    end
    check({tag, "_latency"}, cyc, 16);
    check({tag, "_tok"}, out_token_id, exp_tok);
    check({tag, "_score"}, out_score, exp_score);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, "_stall_vld"}, out_valid, 1);
      check({tag, "_stall_tok"}, out_token_id, exp_tok);
      check({tag, "_stall_score"}, out_score, exp_score);
      check({tag, "_stall_rdy"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_clear_vld"}, out_valid, 0);
    check({tag, "_no_accept"}, in_ready, 1);
    in_valid = 1'b0;
    check({tag, "_keep_tok"}, out_token_id, exp_tok);
    check({tag, "_keep_score"}, out_score, exp_score);
    last_tok   = exp_tok;
    last_score = exp_score;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    last_tok    = 0;
    last_score  = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    in_vec      = '0;

    #2;
    check("rst_vld", out_valid, 0);
    check("rst_rdy", in_ready, 1);
    check("rst_tok", out_token_id, 0);
    check("rst_score", out_score, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn("ones",    splat(8'h01), 15,    988,  0);
    run_txn("neg1",    splat(8'hFF), 0,     -28,  0);
    run_txn("zeros",   splat(8'h00), 0,     0,    0);
    run_txn("tie",     64'h0000_0000_0000_01FF, 0, 1, 0);
    run_txn("max127",  splat(8'h7F), 15,    125476, 0);
    run_txn("min128",  splat(8'h80), 0,     -3584, 5);

    // Reset arriving while row 5 is being evaluated.
    in_vec   = splat(8'hFF);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_vld", out_valid, 0);
    check("midrst_rdy", in_ready, 1);
    check("midrst_tok", out_token_id, 0);
    check("midrst_score", out_score, 0);
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_rdy", in_ready, 1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("postrst_vld", out_valid, 0);
    end
    last_tok   = 0;
    last_score = 0;
    run_txn("after_rst", splat(8'h01), 15, 988, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
